// File: rtl/nx_fifo_arb_pkg.sv
// Shared types and helpers for the nx_fifo write-port arbiter.
package nx_fifo_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOCKED = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_ACK    = 3'd4
  } arb_state_e;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Round-robin successor with wrap at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    if (idx + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr, wrapping upward.
module nx_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  int               cand_s;
  logic [PTR_W-1:0] idx_s;

  // Walk the ring starting at ptr and keep only the first hit.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    cand_s = 0;
    idx_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      idx_s = PTR_W'(cand_s);
      if (!found && valid[idx_s]) begin
        grant[idx_s] = 1'b1;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// Packet-locked round-robin arbiter for a single nx_fifo write port, with flush
// sequencing (drain in-flight packet, pulse clear, acknowledge).
module nx_fifo_wr_arb
  import nx_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 70,
  parameter int DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_eop,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_overflow,
  input  logic                      fifo_underflow,
  output logic                      fifo_wen,
  output logic [DATA_W:0]           fifo_wdata,
  output logic                      fifo_clear,
  input  logic                      flush_req,
  output logic                      flush_ack,
  output logic                      err_sticky
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("nx_fifo_wr_arb: NUM_REQ out of range");
  end
  if (DEPTH < 1 || CNT_W < 1) begin : g_bad_depth
    $error("nx_fifo_wr_arb: DEPTH must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               clear_q, clear_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] pick_grant_s;
  logic               pick_found_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               accept_s;

  nx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant_s),
    .found (pick_found_s)
  );

  // Encode the one-hot winner into an index.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_idx_s = pick_idx_s | (pick_grant_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
    end
  end

  // Next-state, grant and pointer update.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    ready_s   = '0;
    gnt_idx_s = owner_q;
    accept_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_idx_s = pick_idx_s;
        if (flush_req) begin
          state_d = ST_CLEAR;
        end else if (pick_found_s) begin
          ready_s  = pick_grant_s & {NUM_REQ{~fifo_full}};
          accept_s = ~fifo_full;
          if (accept_s && req_eop[pick_idx_s]) begin
            rr_ptr_d = PTR_W'(rr_next(32'(pick_idx_s), NUM_REQ));
          end else if (accept_s) begin
            owner_d = pick_idx_s;
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // LOCKED and DRAIN share the owner-only grant; they differ only in where eop leads.
      ST_LOCKED, ST_DRAIN: begin
        ready_s[owner_q] = ~fifo_full;
        accept_s         = req_valid[owner_q] & ~fifo_full;
        if (accept_s && req_eop[owner_q]) begin
          rr_ptr_d = PTR_W'(rr_next(32'(owner_q), NUM_REQ));
          state_d  = (state_q == ST_DRAIN) ? ST_CLEAR : ST_IDLE;
        end else if (flush_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_CLEAR: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!flush_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    clear_d = (state_d == ST_CLEAR);
    ack_d   = (state_d == ST_ACK);
    err_d   = err_q | fifo_overflow | fifo_underflow;
  end

  // Write-side outputs; ready is forced low while reset is held so nothing transfers.
  always_comb begin
    if (rst) begin
      req_ready = '0;
    end else begin
      req_ready = ready_s;
    end
    fifo_wen = |(req_valid & req_ready);
    if (fifo_wen) begin
      fifo_wdata = {req_eop[gnt_idx_s], req_data[int'(gnt_idx_s) * DATA_W +: DATA_W]};
    end else begin
      fifo_wdata = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      clear_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      clear_q  <= clear_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign fifo_clear = clear_q;
  assign flush_ack  = ack_q;
  assign err_sticky = err_q;

endmodule

// File: doc/nx_fifo_wr_arb.md
# nx_fifo_wr_arb

Packet-aware round-robin arbiter that shares the single write port of an nx_fifo instance between NUM_REQ requesters. Grants stay locked to one requester from first beat through end-of-packet, so packets never interleave in the FIFO. It also sequences FIFO flushes by draining the in-flight packet, pulsing `clear`, then acknowledging. It sits directly in front of an nx_fifo (default 71-bit, DEPTH 2) in the Hardware/DUT partition.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 70: payload width; FIFO word is {eop, data} = DATA_W+1 bits.
- DEPTH, 2: depth of the attached FIFO; sets `CNT_W = $clog2(DEPTH+1)`.
- clk  in  1  sole clock; all state on its rising edge.
- rst  in  1  reset, asynchronous assert, active-high; deassertion is synchronous to clk upstream.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_eop  in  NUM_REQ  per-requester last-beat flag, qualified by valid.
- req_data  in  NUM_REQ*DATA_W  packed payloads; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid & ready.
- fifo_full  in  1  FIFO full.
- fifo_overflow, fifo_underflow  in  1  FIFO error pulses.
- fifo_wen  out  1  FIFO write enable.
- fifo_wdata  out  DATA_W+1  {eop, data} of the granted requester.
- fifo_clear  out  1  FIFO clear, one-cycle pulse.
- flush_req  in  1  level request to flush the FIFO.
- flush_ack  out  1  flush complete; held until flush_req drops.
- err_sticky  out  1  set by any fifo_overflow/underflow; cleared only by rst.

## Operation
- States: IDLE, LOCKED, DRAIN, CLEAR, ACK.
- IDLE: if flush_req, go to CLEAR. Otherwise, the winner is the first valid requester at or after rr_ptr, searching upward with wrap. The winner gets ready = !fifo_full. An accepted beat with eop leaves the state at IDLE and sets rr_ptr = winner+1 mod NUM_REQ. An accepted beat without eop latches owner = winner and goes to LOCKED.
- LOCKED: only owner may be ready, with ready = !fifo_full. An accepted eop beat sets rr_ptr = owner+1 mod NUM_REQ and returns to IDLE. If flush_req arrives in LOCKED, go to DRAIN.
- DRAIN: same as LOCKED, but the accepted eop goes to CLEAR. Flush_req dropping in DRAIN returns to LOCKED.
- CLEAR: all ready low; fifo_clear=1 for exactly this cycle. Then go to ACK.
- ACK: all ready low; flush_ack=1. When flush_req is low, go to IDLE.
- fifo_wen = |(req_valid & req_ready). fifo_wen is never asserted while fifo_full, so the arbiter can never cause overflow.
- fifo_wdata is the granted requester's {eop, data}. It is 0 when there is no grant.
- A requester holding valid without ready must keep its data stable; the arbiter does not check this.
- A non-owner requester's valid has no effect in LOCKED or DRAIN.

## Timing
- Reset values: state=IDLE, rr_ptr=0, owner=0, err_sticky=0. All outputs 0: req_ready, fifo_wen, fifo_wdata, fifo_clear, flush_ack.
- req_ready, fifo_wen and fifo_wdata are combinational from state, rr_ptr, req_valid and fifo_full. Accept-to-FIFO-write latency is 0 cycles, the same edge.
- State, rr_ptr, owner and err_sticky are registered.
- Flush latency from flush_req high in IDLE: fifo_clear on the next cycle, flush_ack the cycle after.
- Full and valid in the same cycle: no accept, and state and rr_ptr do not change.
- An async rst mid-packet or mid-flush returns to IDLE immediately. No clear pulse is generated by reset.

## Structure
- Package nx_fifo_arb_pkg holds the state enum (arb_state_e) and the NUM_REQ bounds check constants.
- Sub-module nx_rr_pick is the combinational round-robin search. It takes valid[NUM_REQ] and ptr, and returns a one-hot grant and a found flag.
- The FIFO itself is not instantiated inside this block.

## Test plan
- Single-beat round-robin: req_valid=4'b1111, all eop=1, fifo never full. Grants go 0,1,2,3,0 on consecutive cycles and fifo_wen=1 every cycle.
- Packet lock: req0 sends a 3-beat packet while req1 is valid throughout. req1's ready stays 0 until req0's eop beat; req1 is granted on the next cycle.
- Backpressure: fifo_full=1 for 5 cycles with req2 valid. req_ready=0 and fifo_wen=0 for those 5 cycles; rr_ptr is unchanged; the accept happens on the cycle full drops.
- Flush in LOCKED: flush_req rises after beat 1 of a 4-beat packet. The remaining 3 beats are accepted; fifo_clear pulses for 1 cycle; flush_ack is held until flush_req drops; then the state returns to IDLE.
- Errors and reset: pulse fifo_overflow once and err_sticky=1 persists. Assert rst mid-packet and all outputs are 0 with rr_ptr=0 in the same cycle.
